// File: rtl/sa1_arb_pkg.sv
// Shared definitions for the ROM bus arbiter: FSM encoding, requester IDs and
// access-counter width.
package sa1_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] PORT_SNES = 2'd0;
  localparam logic [1:0] PORT_SA1  = 2'd1;
  localparam logic [1:0] PORT_MCU  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rom_bus_arbiter_if.sv
// Requester and SRAM0 signals of the ROM bus arbiter; the arbiter uses the
// slave modport, the requesters and memory side use the master modport.
interface rom_bus_arbiter_if;

  logic        snes_req,    sa1_req,    mcu_req;
  logic [23:0] snes_addr,   sa1_addr,   mcu_addr;
  logic        snes_we,     sa1_we,     mcu_we;
  logic [7:0]  snes_wrdata, sa1_wrdata, mcu_wrdata;
  logic        snes_ack,    sa1_ack,    mcu_ack;
  logic [7:0]  rddata;
  logic [23:0] mem_addr;
  logic [7:0]  mem_do;
  logic [7:0]  mem_di;
  logic        mem_we_n;
  logic        mem_oe_n;
  logic        busy;

  modport slave (
    input  snes_req, sa1_req, mcu_req,
    input  snes_addr, sa1_addr, mcu_addr,
    input  snes_we, sa1_we, mcu_we,
    input  snes_wrdata, sa1_wrdata, mcu_wrdata,
    output snes_ack, sa1_ack, mcu_ack,
    output rddata,
    output mem_addr, mem_do, mem_we_n, mem_oe_n,
    input  mem_di,
    output busy
  );

  modport master (
    output snes_req, sa1_req, mcu_req,
    output snes_addr, sa1_addr, mcu_addr,
    output snes_we, sa1_we, mcu_we,
    output snes_wrdata, sa1_wrdata, mcu_wrdata,
    input  snes_ack, sa1_ack, mcu_ack,
    input  rddata,
    input  mem_addr, mem_do, mem_we_n, mem_oe_n,
    output mem_di,
    input  busy
  );

endinterface

// File: rtl/rom_arb_pick.sv
// Combinational winner select: SNES has absolute priority, SA1/MCU share by
// round-robin owner when ROM_ARB_MCU_EN is defined, otherwise SA1 only.
module rom_arb_pick
  import sa1_arb_pkg::*;
(
  input  logic       snes_req,
  input  logic       sa1_req,
`ifdef ROM_ARB_MCU_EN
  input  logic       mcu_req,
  input  logic       rr_owner,
`endif
  output logic       grant_valid,
  output logic [1:0] grant_id
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = PORT_SNES;
    if (snes_req) begin
      grant_valid = 1'b1;
      grant_id    = PORT_SNES;
`ifdef ROM_ARB_MCU_EN
    end else if (sa1_req && mcu_req) begin
      // rr_owner: 0 = SA1 goes first, 1 = MCU goes first
      grant_valid = 1'b1;
      grant_id    = rr_owner ? PORT_MCU : PORT_SA1;
    end else if (mcu_req) begin
      grant_valid = 1'b1;
      grant_id    = PORT_MCU;
`endif
    end else if (sa1_req) begin
      grant_valid = 1'b1;
      grant_id    = PORT_SA1;
    end
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Three-port (SNES/SA1/MCU) arbiter onto a single SRAM0 bus with a fixed
// access length; MCU arbitration is compiled in only with ROM_ARB_MCU_EN.
module rom_bus_arbiter
  import sa1_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 3,
  parameter int RR_INIT       = 0
) (
  input  logic              clk,
  input  logic              rst,
  rom_bus_arbiter_if.slave  bus
);

  localparam bit ONE_CYCLE = (ACCESS_CYCLES == 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_cycle;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic [1:0]       lat_id;
  logic [23:0]      lat_addr;
  logic             lat_we;
  logic [7:0]       lat_wrdata;
  logic [7:0]       rddata_q;

`ifdef ROM_ARB_MCU_EN
  logic rr_owner;

  rom_arb_pick u_pick (
    .snes_req    (bus.snes_req),
    .sa1_req     (bus.sa1_req),
    .mcu_req     (bus.mcu_req),
    .rr_owner    (rr_owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );
`else
  rom_arb_pick u_pick (
    .snes_req    (bus.snes_req),
    .sa1_req     (bus.sa1_req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  wire unused_mcu = ^{bus.mcu_req, bus.mcu_we, bus.mcu_addr, bus.mcu_wrdata, 1'(RR_INIT)};
`endif

  assign last_cycle = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (last_cycle)  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Winner's request is captured at grant so the requester may drop it mid-access.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      lat_id     <= PORT_SNES;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wrdata <= '0;
      rddata_q   <= '0;
`ifdef ROM_ARB_MCU_EN
      rr_owner   <= 1'(RR_INIT);
`endif
    end else if (state == ST_IDLE && grant_valid) begin
      cnt    <= CNT_W'(ACCESS_CYCLES);
      lat_id <= grant_id;
      case (grant_id)
        PORT_SNES: begin
          lat_addr   <= bus.snes_addr;
          lat_we     <= bus.snes_we;
          lat_wrdata <= bus.snes_wrdata;
        end
`ifdef ROM_ARB_MCU_EN
        PORT_MCU: begin
          lat_addr   <= bus.mcu_addr;
          lat_we     <= bus.mcu_we;
          lat_wrdata <= bus.mcu_wrdata;
        end
`endif
        default: begin
          lat_addr   <= bus.sa1_addr;
          lat_we     <= bus.sa1_we;
          lat_wrdata <= bus.sa1_wrdata;
        end
      endcase
`ifdef ROM_ARB_MCU_EN
      if (grant_id == PORT_SA1)      rr_owner <= 1'b1;
      else if (grant_id == PORT_MCU) rr_owner <= 1'b0;
`endif
    end else if (state == ST_ACCESS) begin
      cnt <= cnt - 1'b1;
      if (last_cycle && !lat_we) rddata_q <= bus.mem_di;
    end
  end

  // Write strobe releases one cycle early so data holds past the WE_N rising edge.
  always_comb begin
    bus.busy     = (state != ST_IDLE);
    bus.mem_addr = lat_addr;
    bus.mem_do   = lat_wrdata;
    bus.rddata   = rddata_q;
    bus.mem_we_n = ~((state == ST_ACCESS) && lat_we && (!last_cycle || ONE_CYCLE));
    bus.mem_oe_n = ~((state == ST_ACCESS) && !lat_we);
    bus.snes_ack = (state == ST_DONE) && (lat_id == PORT_SNES);
    bus.sa1_ack  = (state == ST_DONE) && (lat_id == PORT_SA1);
`ifdef ROM_ARB_MCU_EN
    bus.mcu_ack  = (state == ST_DONE) && (lat_id == PORT_MCU);
`else
    bus.mcu_ack  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Scoreboard bench for rom_bus_arbiter: directed requests push expected ACKs,
// a negedge monitor pops and checks them. Adapts to ROM_ARB_MCU_EN.
module tb_rom_bus_arbiter;
  import sa1_arb_pkg::*;

  localparam int AC = 3;

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wrdata;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   we_lo = 0;
  int   oe_lo = 0;
  logic strobe_bad = 1'b0;
  logic [2:0] acks;
  int   k, ac, nlow, nack;
  logic [7:0] do_seen;

  rom_bus_arbiter_if bus();
  rom_bus_arbiter_if bus1();

  rom_bus_arbiter #(.ACCESS_CYCLES(AC), .RR_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rom_bus_arbiter #(.ACCESS_CYCLES(1), .RR_INIT(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  function automatic logic [7:0] mem_model(input logic [23:0] a);
    return a[7:0] ^ 8'hE0;
  endfunction

  assign bus.mem_di  = mem_model(bus.mem_addr);
  assign bus1.mem_di = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expAck(input logic [1:0] port, input logic we, input logic [23:0] addr,
                        input logic [7:0] wrdata);
    exp_t x;
    x.port = port; x.we = we; x.addr = addr; x.wrdata = wrdata;
    sbq.push_back(x);
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [23:0] addr,
                               input logic [7:0] wrdata);
    case (port)
      0: begin bus.snes_addr = addr; bus.snes_we = we; bus.snes_wrdata = wrdata; bus.snes_req = 1'b1; end
      1: begin bus.sa1_addr  = addr; bus.sa1_we  = we; bus.sa1_wrdata  = wrdata; bus.sa1_req  = 1'b1; end
      default: begin bus.mcu_addr = addr; bus.mcu_we = we; bus.mcu_wrdata = wrdata; bus.mcu_req = 1'b1; end
    endcase
  endtask

  task automatic dropReq(input int port);
    case (port)
      0:       bus.snes_req = 1'b0;
      1:       bus.sa1_req  = 1'b0;
      default: bus.mcu_req  = 1'b0;
    endcase
  endtask

  task automatic clearInputs();
    bus.snes_req = 0; bus.sa1_req = 0; bus.mcu_req = 0;
    bus.snes_addr = 0; bus.sa1_addr = 0; bus.mcu_addr = 0;
    bus.snes_we = 0; bus.sa1_we = 0; bus.mcu_we = 0;
    bus.snes_wrdata = 0; bus.sa1_wrdata = 0; bus.mcu_wrdata = 0;
    bus1.snes_req = 0; bus1.sa1_req = 0; bus1.mcu_req = 0;
    bus1.snes_addr = 0; bus1.sa1_addr = 0; bus1.mcu_addr = 0;
    bus1.snes_we = 0; bus1.sa1_we = 0; bus1.mcu_we = 0;
    bus1.snes_wrdata = 0; bus1.sa1_wrdata = 0; bus1.mcu_wrdata = 0;
  endtask

  // Waits for the given port's ACK (sampled mid-DONE), optionally releasing its request.
  task automatic waitAck(input int port, input bit drop, input int limit, output int ack_cycle);
    bit seen;
    seen = 1'b0;
    ack_cycle = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk); #1;
      if ((port == 0 && bus.snes_ack) || (port == 1 && bus.sa1_ack) || (port == 2 && bus.mcu_ack)) begin
        seen = 1'b1;
        ack_cycle = cycle;
      end
    end
    checkOutput($sformatf("ack_arrived_port%0d", port), 32'(seen), 32'd1);
    if (drop) dropReq(port);
  endtask

  // Monitor: accumulate strobe behaviour per access and check it when the ACK arrives.
  always @(negedge clk) begin
    if (rst) begin
      we_lo = 0; oe_lo = 0; strobe_bad = 1'b0;
    end else begin
      if (!bus.mem_we_n) we_lo++;
      if (!bus.mem_oe_n) oe_lo++;
      if ((!bus.mem_we_n || !bus.mem_oe_n) && sbq.size() > 0) begin
        if (bus.mem_addr !== sbq[0].addr) strobe_bad = 1'b1;
        if (!bus.mem_we_n && bus.mem_do !== sbq[0].wrdata) strobe_bad = 1'b1;
      end
      acks = {bus.mcu_ack, bus.sa1_ack, bus.snes_ack};
      if (acks != 3'b000) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_ack", 32'(acks), 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("ack_port", 32'(acks), 32'(3'b001 << e.port));
          checkOutput("we_low_cycles", we_lo, e.we ? ((AC == 1) ? 1 : AC - 1) : 0);
          checkOutput("oe_low_cycles", oe_lo, e.we ? 0 : AC);
          checkOutput("strobe_addr_data", 32'(strobe_bad), 32'd0);
          if (!e.we) checkOutput("rddata", 32'(bus.rddata), 32'(mem_model(e.addr)));
        end
        we_lo = 0; oe_lo = 0; strobe_bad = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy",     32'(bus.busy),     32'd0);
    checkOutput("reset_acks",     32'({bus.mcu_ack, bus.sa1_ack, bus.snes_ack}), 32'd0);
    checkOutput("reset_we_n",     32'(bus.mem_we_n), 32'd1);
    checkOutput("reset_oe_n",     32'(bus.mem_oe_n), 32'd1);
    checkOutput("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("reset_mem_do",   32'(bus.mem_do),   32'd0);
    checkOutput("reset_rddata",   32'(bus.rddata),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All three requesting: SNES, then SA1 (owner), then MCU; second round repeats.
    @(posedge clk); #1;
    expAck(PORT_SNES, 1'b0, 24'h000100, 8'h00);
    expAck(PORT_SA1,  1'b1, 24'h400020, 8'h11);
`ifdef ROM_ARB_MCU_EN
    expAck(PORT_MCU,  1'b1, 24'h7F0033, 8'h44);
`endif
    applyStimulus(0, 1'b0, 24'h000100, 8'h00);
    applyStimulus(1, 1'b1, 24'h400020, 8'h11);
    applyStimulus(2, 1'b1, 24'h7F0033, 8'h44);
    waitAck(0, 1'b1, 20, ac);
    waitAck(1, 1'b1, 20, ac);
`ifdef ROM_ARB_MCU_EN
    waitAck(2, 1'b1, 20, ac);
    expAck(PORT_SNES, 1'b1, 24'h000101, 8'h22);
    expAck(PORT_SA1,  1'b0, 24'h400021, 8'h00);
    expAck(PORT_MCU,  1'b0, 24'h7F0034, 8'h00);
    applyStimulus(0, 1'b1, 24'h000101, 8'h22);
    applyStimulus(1, 1'b0, 24'h400021, 8'h00);
    applyStimulus(2, 1'b0, 24'h7F0034, 8'h00);
    waitAck(0, 1'b1, 20, ac);
    waitAck(1, 1'b1, 20, ac);
    waitAck(2, 1'b1, 20, ac);
`else
    expAck(PORT_SNES, 1'b1, 24'h000101, 8'h22);
    expAck(PORT_SA1,  1'b0, 24'h400021, 8'h00);
    applyStimulus(0, 1'b1, 24'h000101, 8'h22);
    applyStimulus(1, 1'b0, 24'h400021, 8'h00);
    waitAck(0, 1'b1, 20, ac);
    waitAck(1, 1'b1, 20, ac);
`endif

    // SA1 and MCU held continuously with SNES idle.
    @(posedge clk); #1;
`ifdef ROM_ARB_MCU_EN
    expAck(PORT_SA1, 1'b0, 24'h400100, 8'h00);
    expAck(PORT_MCU, 1'b0, 24'h7F0100, 8'h00);
    expAck(PORT_SA1, 1'b0, 24'h400100, 8'h00);
    expAck(PORT_MCU, 1'b0, 24'h7F0100, 8'h00);
    applyStimulus(1, 1'b0, 24'h400100, 8'h00);
    applyStimulus(2, 1'b0, 24'h7F0100, 8'h00);
    waitAck(1, 1'b0, 20, ac);
    waitAck(2, 1'b0, 20, ac);
    waitAck(1, 1'b0, 20, ac);
    waitAck(2, 1'b1, 20, ac);
    dropReq(1);
`else
    expAck(PORT_SA1, 1'b0, 24'h400100, 8'h00);
    expAck(PORT_SA1, 1'b0, 24'h400100, 8'h00);
    expAck(PORT_SA1, 1'b0, 24'h400100, 8'h00);
    applyStimulus(1, 1'b0, 24'h400100, 8'h00);
    waitAck(1, 1'b0, 20, ac);
    waitAck(1, 1'b0, 20, ac);
    waitAck(1, 1'b1, 20, ac);

    // MCU write request alone, left high for 50 cycles, must be ignored.
    nlow = 0; nack = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.mem_we_n) nlow++;
      if (bus.mcu_ack) nack++;
    end
    checkOutput("mcu_disabled_ack",  nack, 0);
    checkOutput("mcu_disabled_we_n", nlow, 0);
    dropReq(2);
`endif

    // SA1 read: OE_N low 3 cycles, ACK four cycles after issue, RDDATA = 0xA5.
    @(posedge clk); #1;
    k = cycle;
    expAck(PORT_SA1, 1'b0, 24'h012345, 8'h00);
    applyStimulus(1, 1'b0, 24'h012345, 8'h00);
    waitAck(1, 1'b1, 20, ac);
    checkOutput("sa1_read_latency", ac - k, AC + 1);
    @(negedge clk);
    checkOutput("rddata_hold_idle", 32'(bus.rddata), 32'h0000_00A5);

    // SNES write: WE_N low 2 cycles with MEM_DO = 0x3C; read data must not change.
    @(posedge clk); #1;
    k = cycle;
    expAck(PORT_SNES, 1'b1, 24'hE00010, 8'h3C);
    applyStimulus(0, 1'b1, 24'hE00010, 8'h3C);
    waitAck(0, 1'b1, 20, ac);
    checkOutput("snes_write_latency", ac - k, AC + 1);
    checkOutput("rddata_hold_write", 32'(bus.rddata), 32'h0000_00A5);

    // Reset during the second ACCESS cycle of a write aborts it without ACK.
    @(posedge clk); #1;
`ifdef ROM_ARB_MCU_EN
    applyStimulus(2, 1'b1, 24'h7F0200, 8'h5A);
`else
    applyStimulus(1, 1'b1, 24'h7F0200, 8'h5A);
`endif
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    dropReq(1);
    dropReq(2);
    @(negedge clk);
    checkOutput("abort_we_n_active", 32'(bus.mem_we_n), 32'd0);
    checkOutput("abort_busy_active", 32'(bus.busy),     32'd1);
    @(negedge clk);
    checkOutput("abort_we_n_released", 32'(bus.mem_we_n), 32'd1);
    checkOutput("abort_busy_cleared",  32'(bus.busy),     32'd0);
    checkOutput("abort_no_ack", 32'({bus.mcu_ack, bus.sa1_ack, bus.snes_ack}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // Single-cycle access instance: write strobe held for the only ACCESS cycle.
    @(posedge clk); #1;
    k = cycle;
    bus1.sa1_addr = 24'h000042; bus1.sa1_we = 1'b1; bus1.sa1_wrdata = 8'h99; bus1.sa1_req = 1'b1;
    nlow = 0; ac = -1; do_seen = 8'h00;
    for (int i = 0; i < 10 && ac < 0; i++) begin
      @(negedge clk); #1;
      if (!bus1.mem_we_n) begin
        nlow++;
        do_seen = bus1.mem_do;
      end
      if (bus1.sa1_ack) begin
        ac = cycle;
        bus1.sa1_req = 1'b0;
      end
    end
    checkOutput("ac1_we_low_cycles", nlow, 1);
    checkOutput("ac1_latency", ac - k, 2);
    checkOutput("ac1_mem_do", 32'(do_seen), 32'h0000_0099);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
